rr_hold_arb: RTL and testbench

Parameterised, registered round-robin arbiter with grant hold for a shared resource with multiple requesters. Next generation of the team's fixed-priority arbiter. It adds the following:
- rotating priority, so no requester starves;
- a grant that is held while its requester keeps requesting;
- zero-bubble hand-over between requesters;
- an optional hold-time limit that forces rotation.

It sits in front of any shared single-owner resource, such as a bus master port or a memory bank.

---
 rtl/rr_hold_arb.sv | 164 ++++++++++++++++
 tb/tb_rr_hold_arb.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/rr_hold_arb.sv
// Registered round-robin arbiter with grant hold and zero-bubble hand-over.
// Define RR_HOLD_ARB_LIMIT_EN to compile in the hold-time limit (forced rotation, expire_o).
module rr_hold_arb #(
    parameter int  NUM_PORTS = 5,
    parameter int  MAX_HOLD  = 8,
    localparam int IDW       = ($clog2(NUM_PORTS) > 1) ? $clog2(NUM_PORTS) : 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_PORTS-1:0] req_i,
    output logic [NUM_PORTS-1:0] gnt_o,
    output logic                 gnt_valid_o,
    output logic [IDW-1:0]       gnt_id_o,
    output logic                 expire_o
);

    typedef enum logic {IDLE, GRANT} state_e;

    state_e               state_q, state_d;
    logic [IDW-1:0]       ptr_q, ptr_d;
    logic [IDW-1:0]       id_q, id_d;
    logic [NUM_PORTS-1:0] own_vec;
    logic [NUM_PORTS-1:0] others;
    logic                 owner_req;
    logic                 force_rot;
    logic [IDW-1:0]       ptr_next;
    logic [IDW:0]         win;

    generate
        if (NUM_PORTS < 2 || MAX_HOLD < 1) begin : g_bad_params
            $error("rr_hold_arb: NUM_PORTS must be >= 2 and MAX_HOLD >= 1");
        end
    endgenerate

    // Cyclic first-set search starting at 'start'; MSB of the result flags a winner.
    function automatic logic [IDW:0] find_winner(input logic [NUM_PORTS-1:0] vec,
                                                 input logic [IDW-1:0]       start);
        logic           found;
        logic [IDW-1:0] idx;
        found = 1'b0;
        idx   = '0;
        for (int j = 0; j < NUM_PORTS; j++) begin
            if (!found && vec[j] && IDW'(j) >= start) begin
                found = 1'b1;
                idx   = IDW'(j);
            end
        end
        for (int j = 0; j < NUM_PORTS; j++) begin
            if (!found && vec[j] && IDW'(j) < start) begin
                found = 1'b1;
                idx   = IDW'(j);
            end
        end
        return {found, idx};
    endfunction

    always_comb begin
        own_vec = '0;
        for (int j = 0; j < NUM_PORTS; j++) begin
            own_vec[j] = (id_q == IDW'(j));
        end
    end

    assign owner_req = |(req_i & own_vec);
    assign others    = req_i & ~own_vec;
    assign ptr_next  = (id_q == IDW'(NUM_PORTS - 1)) ? '0 : id_q + IDW'(1);

`ifdef RR_HOLD_ARB_LIMIT_EN
    localparam int CW = $clog2(MAX_HOLD + 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          expire_q;
    logic          new_grant;

    assign force_rot = (state_q == GRANT) && (cnt_q == CW'(MAX_HOLD)) && owner_req && (|others);

    // A fresh owner starts at 1; a held owner counts up and saturates at the limit.
    always_comb begin
        new_grant = (state_d == GRANT) &&
                    ((state_q == IDLE) || !owner_req || force_rot);
        cnt_d = cnt_q;
        if (new_grant) begin
            cnt_d = CW'(1);
        end else if (state_d == IDLE) begin
            cnt_d = '0;
        end else if (cnt_q != CW'(MAX_HOLD)) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q    <= '0;
            expire_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            expire_q <= force_rot;
        end
    end

    assign expire_o = expire_q;
`else
    assign force_rot = 1'b0;
    assign expire_o  = 1'b0;
`endif

    // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        id_d    = id_q;
        win     = '0;
        case (state_q)
            IDLE: begin
                win = find_winner(req_i, ptr_q);
                if (win[IDW]) begin
                    state_d = GRANT;
                    id_d    = win[IDW-1:0];
                end
            end
            GRANT: begin
                if (!owner_req || force_rot) begin
                    ptr_d = ptr_next;
                    win   = find_winner(others, ptr_next);
                    if (win[IDW]) begin
                        id_d = win[IDW-1:0];
                    end else begin
                        state_d = IDLE;
                        id_d    = '0;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                id_d    = '0;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all flops sample the same pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            id_q    <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            id_q    <= id_d;
        end
    end

    // Grant vector, valid and id are all decoded from the same registers, so they never disagree.
    always_comb begin
        gnt_o = '0;
        if (state_q == GRANT) begin
            gnt_o = own_vec;
        end
    end

    assign gnt_valid_o = (state_q == GRANT);
    assign gnt_id_o    = id_q;

endmodule

// File: tb/tb_rr_hold_arb.sv
// Self-checking bench for rr_hold_arb: directed vector table, hold-limit sequences,
// then randomized traffic against a behavioural round-robin model.
module tb_rr_hold_arb;

    localparam int NP  = 5;
    localparam int MH  = 4;
    localparam int IDW = 3;
`ifdef RR_HOLD_ARB_LIMIT_EN
    localparam bit LIMIT_EN = 1'b1;
`else
    localparam bit LIMIT_EN = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic [NP-1:0]  req = '0;
    logic [NP-1:0]  gnt;
    logic           gnt_valid;
    logic [IDW-1:0] gnt_id;
    logic           expire;

    int n_pass  = 0;
    int n_total = 0;

    // Behavioural model state
    bit m_busy;
    int m_owner;
    int m_ptr;
    int m_hold;
    bit m_expire;

    typedef struct {
        logic          rst;
        logic [NP-1:0] req;
        logic [NP-1:0] gnt;
        int            id;
    } vec_t;

    vec_t tbl[$];

    rr_hold_arb #(.NUM_PORTS(NP), .MAX_HOLD(MH)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_i      (req),
        .gnt_o      (gnt),
        .gnt_valid_o(gnt_valid),
        .gnt_id_o   (gnt_id),
        .expire_o   (expire)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    function automatic int pick(input logic [NP-1:0] v, input int start);
        for (int k = 0; k < NP; k++) begin
            int p;
            p = (start + k) % NP;
            if (v[p]) return p;
        end
        return -1;
    endfunction

    // Advance the model by one clock edge using the inputs currently applied.
    task automatic model_step();
        logic [NP-1:0] oth;
        bit            rot;
        int            w;
        if (reset) begin
            m_busy = 0; m_owner = 0; m_ptr = 0; m_hold = 0; m_expire = 0;
        end else if (!m_busy) begin
            m_expire = 0;
            w = pick(req, m_ptr);
            if (w >= 0) begin
                m_busy = 1; m_owner = w; m_hold = 1;
            end
        end else begin
            oth = req;
            oth[m_owner] = 1'b0;
            rot = LIMIT_EN && (m_hold >= MH) && req[m_owner] && (oth != 0);
            if (!req[m_owner] || rot) begin
                m_ptr    = (m_owner + 1) % NP;
                m_expire = rot;
                w = pick(oth, m_ptr);
                if (w >= 0) begin
                    m_owner = w; m_hold = 1;
                end else begin
                    m_busy = 0; m_owner = 0; m_hold = 0;
                end
            end else begin
                m_expire = 0;
                m_hold   = (m_hold < MH) ? m_hold + 1 : MH;
            end
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_model(input string tag);
        logic [NP-1:0] eg;
        eg = m_busy ? NP'(1) << m_owner : '0;
        check({tag, ".gnt"},    32'(gnt),       32'(eg));
        check({tag, ".valid"},  32'(gnt_valid), 32'(m_busy));
        check({tag, ".id"},     32'(gnt_id),    32'(m_owner));
        check({tag, ".expire"}, 32'(expire),    32'(m_expire));
    endtask

    initial begin
        tbl.push_back('{1'b1, 5'b11111, 5'b00000, 0});
        tbl.push_back('{1'b1, 5'b11111, 5'b00000, 0});
        tbl.push_back('{1'b0, 5'b11111, 5'b00001, 0});
        tbl.push_back('{1'b0, 5'b00101, 5'b00001, 0});
        tbl.push_back('{1'b0, 5'b00100, 5'b00100, 2});
        tbl.push_back('{1'b0, 5'b00001, 5'b00001, 0});
        tbl.push_back('{1'b0, 5'b00000, 5'b00000, 0});
        tbl.push_back('{1'b0, 5'b00100, 5'b00100, 2});
        tbl.push_back('{1'b0, 5'b00000, 5'b00000, 0});
        tbl.push_back('{1'b0, 5'b10011, 5'b10000, 4});
        tbl.push_back('{1'b0, 5'b00000, 5'b00000, 0});
        tbl.push_back('{1'b0, 5'b01000, 5'b01000, 3});
        tbl.push_back('{1'b0, 5'b00000, 5'b00000, 0});
        tbl.push_back('{1'b0, 5'b11000, 5'b10000, 4});
        tbl.push_back('{1'b0, 5'b00000, 5'b00000, 0});
        tbl.push_back('{1'b0, 5'b00010, 5'b00010, 1});
        tbl.push_back('{1'b0, 5'b00000, 5'b00000, 0});
        tbl.push_back('{1'b0, 5'b00100, 5'b00100, 2});
        tbl.push_back('{1'b1, 5'b00100, 5'b00000, 0});
        tbl.push_back('{1'b0, 5'b00101, 5'b00001, 0});
        tbl.push_back('{1'b0, 5'b00000, 5'b00000, 0});

        // Directed table
        for (int i = 0; i < tbl.size(); i++) begin
            reset = tbl[i].rst;
            req   = tbl[i].req;
            tick();
            check($sformatf("tbl%0d.gnt", i),    32'(gnt),       32'(tbl[i].gnt));
            check($sformatf("tbl%0d.id", i),     32'(gnt_id),    32'(tbl[i].id));
            check($sformatf("tbl%0d.valid", i),  32'(gnt_valid), 32'(tbl[i].gnt != 0));
            check($sformatf("tbl%0d.expire", i), 32'(expire),    32'h0);
        end

        // Contended hold: alternation every MH cycles with the limit, otherwise port 0 keeps it
        reset = 1'b1; req = 5'b00011;
        tick();
        reset = 1'b0;
        for (int k = 0; k < 4 * MH; k++) begin
            int            own;
            logic [NP-1:0] eg;
            tick();
            own = LIMIT_EN ? (k / MH) % 2 : 0;
            eg  = NP'(1) << own;
            check($sformatf("hold%0d.gnt", k),    32'(gnt),    32'(eg));
            check($sformatf("hold%0d.expire", k), 32'(expire), 32'(LIMIT_EN && k > 0 && (k % MH) == 0));
        end

        // Uncontended owner keeps the grant past the limit
        reset = 1'b1; req = 5'b00001;
        tick();
        reset = 1'b0;
        for (int k = 0; k < 3 * MH; k++) begin
            tick();
            check($sformatf("solo%0d.gnt", k),    32'(gnt),    32'h1);
            check($sformatf("solo%0d.expire", k), 32'(expire), 32'h0);
        end

        // Randomized traffic against the model
        for (int k = 0; k < 600; k++) begin
            reset = ($urandom_range(0, 59) == 0);
            if ($urandom_range(0, 19) == 0) req = '0;
            else req = req ^ NP'($urandom & $urandom);
            tick();
            check_model($sformatf("rnd%0d", k));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
